// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans an NROWS x NCOLS active-low matrix keypad one column at a
//            time. It debounces press and release over whole scan frames and
//            rejects frames that contain more than one key. It emits a
//            registered key code with a one-cycle valid strobe, and can
//            optionally auto-repeat while a key is held.
// Ports    : clk        - system clock
//            reset      - asynchronous, active-high reset
//            kpr        - row inputs, active low, asynchronous to clk
//            kpc        - registered column drive, exactly one bit low
//            key_code   - row*NCOLS + col of the accepted key
//            key_valid  - 1-cycle strobe on a new press or an auto-repeat
//            key_held   - high from an accepted press until an accepted release
//            multi_err  - 1-cycle strobe after a frame that saw two or more keys
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int NROWS       = 4,
    parameter int NCOLS       = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 0,
    parameter int REPEAT_RATE = 8,
    localparam int CW = (NROWS * NCOLS > 1) ? $clog2(NROWS * NCOLS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NROWS-1:0] kpr,
    output logic [NCOLS-1:0] kpc,
    output logic [CW-1:0]    key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             multi_err
);

    localparam int c_DIV_W   = $clog2(SCAN_DIV);
    localparam int c_COL_W   = $clog2(NCOLS);
    localparam int c_ROW_W   = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int c_DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int c_RPT_MAX = (REPEAT_DLY > 0) ? REPEAT_DLY : 1;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam int c_RATE_W  = $clog2(REPEAT_RATE + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_COL_W-1:0]  c_COL_LAST = c_COL_W'(NCOLS - 1);
    localparam logic [c_COL_W-1:0]  c_COL_ONE  = c_COL_W'(1);
    localparam logic [NCOLS-1:0]    c_KPC_BIT0 = NCOLS'(1);
    localparam logic [c_DEB_W-1:0]  c_DEB_N    = c_DEB_W'(DEBOUNCE);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_RPT_W-1:0]  c_RPT_N    = c_RPT_W'(c_RPT_MAX);
    localparam logic [c_RPT_W-1:0]  c_RPT_ONE  = c_RPT_W'(1);
    localparam logic [c_RATE_W-1:0] c_RATE_N   = c_RATE_W'(REPEAT_RATE);
    localparam logic [c_RATE_W-1:0] c_RATE_ONE = c_RATE_W'(1);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_DEB     = 2'd1;
    localparam logic [1:0] c_S_PRESSED = 2'd2;
    localparam logic [1:0] c_S_REL     = 2'd3;

    // Registers
    logic [NROWS-1:0]    r_kpr_m, r_kpr_s;
    logic [c_DIV_W-1:0]  r_dwell;
    logic [c_COL_W-1:0]  r_col;
    logic [NCOLS-1:0]    r_kpc;
    logic [1:0]          r_acc_n;      // keys seen so far this frame, saturates at 2
    logic [CW-1:0]       r_acc_code;
    logic [1:0]          r_state;
    logic [CW-1:0]       r_cand;
    logic [c_DEB_W-1:0]  r_cnt;
    logic [c_DEB_W-1:0]  r_rcnt;
    logic [c_RPT_W-1:0]  r_rpt;        // saturates at REPEAT_DLY
    logic [c_RATE_W-1:0] r_rate;
    logic [CW-1:0]       r_key_code;
    logic                r_key_valid, r_key_held, r_multi_err;

    // Combinational
    logic                w_sample, w_frame_end;
    logic [c_COL_W-1:0]  w_col_nxt;
    logic [1:0]          w_col_n;
    logic [c_ROW_W-1:0]  w_col_row;
    logic [CW-1:0]       w_col_code;
    logic [1:0]          w_tot_n;
    logic [CW-1:0]       w_tot_code;
    logic                w_none, w_single, w_multi, w_accept;
    logic [1:0]          w_nxt_state;
    logic [CW-1:0]       w_nxt_cand, w_nxt_code;
    logic [c_DEB_W-1:0]  w_nxt_cnt, w_nxt_rcnt;
    logic [c_RPT_W-1:0]  w_nxt_rpt;
    logic [c_RATE_W-1:0] w_nxt_rate;
    logic                w_nxt_valid, w_nxt_held, w_nxt_multi;

    assign w_sample    = (r_dwell == c_DIV_LAST);
    assign w_frame_end = w_sample && (r_col == c_COL_LAST);
    assign w_col_nxt   = (r_col == c_COL_LAST) ? '0 : r_col + c_COL_ONE;

    // Count low rows in the driven column (saturating at 2) and remember one.
    always_comb begin
        w_col_n   = 2'd0;
        w_col_row = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (!r_kpr_s[i]) begin
                if (w_col_n != 2'd2) w_col_n = w_col_n + 2'd1;
                w_col_row = c_ROW_W'(i);
            end
        end
    end

    assign w_col_code = CW'(int'(w_col_row) * NCOLS + int'(r_col));

    // Merge this column into the frame tally; only meaningful when w_sample.
    always_comb begin
        w_tot_n    = r_acc_n;
        w_tot_code = r_acc_code;
        if (w_col_n == 2'd2) begin
            w_tot_n = 2'd2;
        end else if (w_col_n == 2'd1) begin
            if (r_acc_n == 2'd0) begin
                w_tot_n    = 2'd1;
                w_tot_code = w_col_code;
            end else begin
                w_tot_n = 2'd2;
            end
        end
    end

    assign w_none   = (w_tot_n == 2'd0);
    assign w_single = (w_tot_n == 2'd1);
    assign w_multi  = (w_tot_n == 2'd2);

    // Next-state and output logic, evaluated only at frame end.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cand  = r_cand;
        w_nxt_cnt   = r_cnt;
        w_nxt_rcnt  = r_rcnt;
        w_nxt_rpt   = r_rpt;
        w_nxt_rate  = r_rate;
        w_nxt_code  = r_key_code;
        w_nxt_held  = r_key_held;
        w_nxt_valid = 1'b0;
        w_accept    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_single) begin
                        w_nxt_cand = w_tot_code;
                        if (DEBOUNCE == 1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_nxt_state = c_S_DEB;
                            w_nxt_cnt   = c_DEB_ONE;
                        end
                    end
                end
                c_S_DEB: begin
                    if (w_single && (w_tot_code == r_cand)) begin
                        if (r_cnt + c_DEB_ONE == c_DEB_N) w_accept = 1'b1;
                        else                              w_nxt_cnt = r_cnt + c_DEB_ONE;
                    end else begin
                        w_nxt_state = c_S_IDLE;
                        w_nxt_cnt   = '0;
                    end
                end
                c_S_PRESSED: begin
                    if (w_none) begin
                        if (DEBOUNCE == 1) begin
                            w_nxt_state = c_S_IDLE;
                            w_nxt_held  = 1'b0;
                        end else begin
                            w_nxt_state = c_S_REL;
                            w_nxt_rcnt  = c_DEB_ONE;
                        end
                    end else if (REPEAT_DLY > 0) begin
                        // Initial delay first, then a free-running rate divider.
                        if (r_rpt != c_RPT_N) begin
                            w_nxt_rpt = r_rpt + c_RPT_ONE;
                            if (r_rpt + c_RPT_ONE == c_RPT_N) w_nxt_valid = 1'b1;
                        end else if (r_rate + c_RATE_ONE == c_RATE_N) begin
                            w_nxt_valid = 1'b1;
                            w_nxt_rate  = '0;
                        end else begin
                            w_nxt_rate = r_rate + c_RATE_ONE;
                        end
                    end
                end
                c_S_REL: begin
                    if (w_none) begin
                        if (r_rcnt + c_DEB_ONE == c_DEB_N) begin
                            w_nxt_state = c_S_IDLE;
                            w_nxt_held  = 1'b0;
                            w_nxt_rcnt  = '0;
                        end else begin
                            w_nxt_rcnt = r_rcnt + c_DEB_ONE;
                        end
                    end else begin
                        // Bounce during release: back to held, repeat timing kept.
                        w_nxt_state = c_S_PRESSED;
                        w_nxt_rcnt  = '0;
                    end
                end
                default: w_nxt_state = c_S_IDLE;
            endcase
            if (w_accept) begin
                w_nxt_state = c_S_PRESSED;
                w_nxt_code  = w_tot_code;
                w_nxt_held  = 1'b1;
                w_nxt_valid = 1'b1;
                w_nxt_cnt   = '0;
                w_nxt_rpt   = '0;
                w_nxt_rate  = '0;
            end
        end
    end

    assign w_nxt_multi = w_frame_end && w_multi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kpr_m     <= '1;
            r_kpr_s     <= '1;
            r_dwell     <= '0;
            r_col       <= '0;
            r_kpc       <= ~c_KPC_BIT0;
            r_acc_n     <= 2'd0;
            r_acc_code  <= '0;
            r_state     <= c_S_IDLE;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_rcnt      <= '0;
            r_rpt       <= '0;
            r_rate      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_kpr_m <= kpr;
            r_kpr_s <= r_kpr_m;
            if (w_sample) begin
                r_dwell <= '0;
                r_col   <= w_col_nxt;
                r_kpc   <= ~(c_KPC_BIT0 << w_col_nxt);
            end else begin
                r_dwell <= r_dwell + c_DIV_ONE;
            end
            if (w_frame_end) begin
                r_acc_n    <= 2'd0;
                r_acc_code <= '0;
            end else if (w_sample) begin
                r_acc_n    <= w_tot_n;
                r_acc_code <= w_tot_code;
            end
            r_state     <= w_nxt_state;
            r_cand      <= w_nxt_cand;
            r_cnt       <= w_nxt_cnt;
            r_rcnt      <= w_nxt_rcnt;
            r_rpt       <= w_nxt_rpt;
            r_rate      <= w_nxt_rate;
            r_key_code  <= w_nxt_code;
            r_key_valid <= w_nxt_valid;
            r_key_held  <= w_nxt_held;
            r_multi_err <= w_nxt_multi;
        end
    end

    assign kpc       = r_kpc;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_err = r_multi_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner. A keypad model turns a
//            16-bit "keys pressed" mask into row levels from the column drive.
//            Expected strobes are queued with their cycle number; a monitor
//            pops and compares them whenever the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int NROWS       = 4;
    localparam int NCOLS       = 4;
    localparam int SCAN_DIV    = 4;
    localparam int DEBOUNCE    = 3;
    localparam int REPEAT_DLY  = 4;
    localparam int REPEAT_RATE = 2;
    localparam int FRAME       = NCOLS * SCAN_DIV;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NROWS-1:0] kpr;
    logic [NCOLS-1:0] kpc;
    logic [3:0]       key_code;
    logic             key_valid, key_held, multi_err;

    logic [15:0] pressed = 16'h0000;
    int errors = 0;
    int checks = 0;
    int cyc;
    int fr = 0;

    typedef struct { int code; int cyc; } ev_t;
    ev_t q_valid[$];
    int  q_multi[$];

    keypad_scanner #(
        .NROWS(NROWS), .NCOLS(NCOLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
        .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk(clk), .reset(reset), .kpr(kpr), .kpc(kpc), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kpr = '1;
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++)
                if (!kpc[c] && pressed[r*NCOLS+c]) kpr[r] = 1'b0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_valid(input int code, input int frame);
        ev_t e;
        e.code = code;
        e.cyc  = frame * FRAME;
        q_valid.push_back(e);
    endtask

    // Apply a key mask for n whole frames, ending 1 time unit after the frame-end edge.
    task automatic do_frames(input logic [15:0] keys, input int n);
        pressed = keys;
        repeat (n) begin
            repeat (FRAME) @(posedge clk);
            #1;
            fr++;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid === 1'b1) begin
                if (q_valid.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected key_valid: got strobe code %0d at cycle %0d, expected none",
                             key_code, cyc);
                end else begin
                    ev_t e;
                    e = q_valid.pop_front();
                    check("valid_code", 32'(key_code), e.code);
                    check("valid_cycle", cyc, e.cyc);
                end
            end
            if (multi_err === 1'b1) begin
                if (q_multi.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected multi_err: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    check("multi_cycle", cyc, q_multi.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_kpc", 32'(kpc), 32'h0000000E);
        check("rst_code", 32'(key_code), 0);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_multi", 32'(multi_err), 0);
        reset = 1'b0;
        fr = 0;

        // 1: r1/c2 (code 6) held 6 frames, then released
        expect_valid(6, fr + 3);
        do_frames(16'h0040, 6);
        check("t1_held", 32'(key_held), 1);
        check("t1_code", 32'(key_code), 6);
        check("t1_kpc_frame_start", 32'(kpc), 32'h0000000E);
        do_frames(16'h0000, 2);
        check("t1_held_rel2", 32'(key_held), 1);
        do_frames(16'h0000, 1);
        check("t1_held_rel3", 32'(key_held), 0);

        // 2: bounce on r0/c0
        do_frames(16'h0001, 2);
        do_frames(16'h0000, 1);
        do_frames(16'h0001, 2);
        check("t2_held", 32'(key_held), 0);
        do_frames(16'h0000, 1);

        // 3: r0/c1 + r3/c3 together for 4 frames
        for (int i = 1; i <= 4; i++) q_multi.push_back((fr + i) * FRAME);
        do_frames(16'h8002, 4);
        check("t3_held", 32'(key_held), 0);
        do_frames(16'h0000, 1);

        // 4: auto-repeat, r2/c0 (code 8) held 12 frames
        expect_valid(8, fr + 3);
        expect_valid(8, fr + 7);
        expect_valid(8, fr + 9);
        expect_valid(8, fr + 11);
        do_frames(16'h0100, 12);
        check("t4_code", 32'(key_code), 8);
        check("t4_held", 32'(key_held), 1);
        do_frames(16'h0000, 3);
        check("t4_held_rel", 32'(key_held), 0);

        // 5: re-press during release debounce is not a new press
        expect_valid(5, fr + 3);
        do_frames(16'h0020, 3);
        do_frames(16'h0000, 2);
        check("t5_held_a", 32'(key_held), 1);
        do_frames(16'h0020, 1);
        do_frames(16'h0000, 2);
        check("t5_held_b", 32'(key_held), 1);
        do_frames(16'h0000, 1);
        check("t5_held_c", 32'(key_held), 0);
        check("t5_code", 32'(key_code), 5);

        // 6: reset in the middle of debounce (two good frames of r2/c2)
        do_frames(16'h0400, 2);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_kpc", 32'(kpc), 32'h0000000E);
        check("t6_code", 32'(key_code), 0);
        check("t6_valid", 32'(key_valid), 0);
        check("t6_held", 32'(key_held), 0);
        check("t6_multi", 32'(multi_err), 0);
        pressed = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fr = 0;
        do_frames(16'h0000, 1);
        expect_valid(10, fr + 3);
        do_frames(16'h0400, 3);
        check("t6_held_press", 32'(key_held), 1);
        check("t6_code_press", 32'(key_code), 10);
        do_frames(16'h0000, 3);
        check("t6_held_rel", 32'(key_held), 0);

        repeat (4) @(negedge clk);
        check("pending_valid", q_valid.size(), 0);
        check("pending_multi", q_multi.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
